// File: rtl/disp_share_arbiter_if.sv
// disp_share_arbiter_if: request/frame inputs and grant/digit outputs of the display-share arbiter
interface disp_share_arbiter_if;
  logic [3:0] req;
  logic [19:0] frame0, frame1, frame2, frame3;
  logic [3:0] grant;
  logic [4:0] disp0, disp1, disp2, disp3;
  logic busy;
  modport master (
    output req, frame0, frame1, frame2, frame3,
    input grant, disp0, disp1, disp2, disp3, busy
  );
  modport slave (
    input req, frame0, frame1, frame2, frame3,
    output grant, disp0, disp1, disp2, disp3, busy
  );
endinterface

// File: rtl/disp_share_arbiter.sv
// disp_share_arbiter: round-robin, hold-timed sharing of one 4-digit display among 4 requesters
// Optional DISP_ARB_PRIORITY_EN: requester 0 preempts and keeps the display while it requests.
module disp_share_arbiter #(
  parameter int NBITS_HOLD = 26,
  parameter int HOLD = 50_000_000,
  parameter logic [4:0] BLANK_CODE = 5'h1F
) (
  input logic clk,
  input logic rst,
  disp_share_arbiter_if.slave bus
);
  typedef enum logic {IDLE, SHOW} state_t;
  localparam logic [NBITS_HOLD-1:0] HMAX = NBITS_HOLD'(HOLD - 1);
  localparam logic [NBITS_HOLD-1:0] ONE = NBITS_HOLD'(1);
  state_t state, state_n;
  logic [3:0] grant, grant_n, mreq;
  logic [1:0] last, last_n, win, tgt, k;
  logic [NBITS_HOLD-1:0] cnt, cnt_n;
  logic found, own, take, drop;
  logic [19:0] frame_n;
  logic [4:0] disp [4];
  always_comb begin
    mreq = bus.req & ~grant;
    own = |(bus.req & grant);
    win = last;
    found = 1'b0;
    k = '0;
    // search starts one past the last owner; the owner itself is masked out
    for (int i = 1; i <= 4; i++) begin
      k = last + 2'(i);
      if (!found && mreq[k]) begin
        win = k;
        found = 1'b1;
      end
    end
    state_n = state;
    grant_n = grant;
    last_n = last;
    cnt_n = cnt;
    take = 1'b0;
    drop = 1'b0;
    tgt = win;
    if (state == IDLE) begin
      take = found;
`ifdef DISP_ARB_PRIORITY_EN
      tgt = bus.req[0] ? 2'd0 : win;
`endif
    end
`ifdef DISP_ARB_PRIORITY_EN
    else if (bus.req[0] && !grant[0]) begin
      take = 1'b1;
      tgt = 2'd0;
    end
    else if (grant[0] && own) cnt_n = (cnt == HMAX) ? '0 : cnt + ONE;
`endif
    else if (!own) begin
      take = found;
      drop = !found;
    end
    else if (cnt == HMAX) begin
      take = found;
      cnt_n = '0;
    end
    else cnt_n = cnt + ONE;
    if (take) begin
      state_n = SHOW;
      grant_n = 4'b0001 << tgt;
      last_n = tgt;
      cnt_n = '0;
    end
    if (drop) begin
      state_n = IDLE;
      grant_n = '0;
      cnt_n = '0;
    end
    frame_n = last_n == 2'd0 ? bus.frame0 :
              last_n == 2'd1 ? bus.frame1 :
              last_n == 2'd2 ? bus.frame2 : bus.frame3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      cnt <= '0;
      last <= 2'd3;
      for (int i = 0; i < 4; i++) disp[i] <= BLANK_CODE;
    end else begin
      state <= state_n;
      grant <= grant_n;
      cnt <= cnt_n;
      last <= last_n;
      for (int i = 0; i < 4; i++) disp[i] <= |grant_n ? frame_n[5*i +: 5] : BLANK_CODE;
    end
  end
  assign bus.grant = grant;
  assign bus.busy = |grant;
  assign bus.disp0 = disp[0];
  assign bus.disp1 = disp[1];
  assign bus.disp2 = disp[2];
  assign bus.disp3 = disp[3];
endmodule

// File: tb/tb_disp_share_arbiter.sv
// tb_disp_share_arbiter: directed-vector bench for disp_share_arbiter with HOLD=4
module tb_disp_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] disp_all;
  disp_share_arbiter_if bus();
  disp_share_arbiter #(.NBITS_HOLD(4), .HOLD(4), .BLANK_CODE(5'h1F)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  assign disp_all = {bus.disp3, bus.disp2, bus.disp1, bus.disp0};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.frame0 = 20'h0A0A0;
    bus.frame1 = 20'h00421;
    bus.frame2 = 20'h08888;
    bus.frame3 = 20'h18C63;
    step();
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_disp", 32'(disp_all), 32'hFFFFF);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("idle_grant", 32'(bus.grant), 32'h0);
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("idle_disp", 32'(disp_all), 32'hFFFFF);
    // requesters 1 and 3 alternate every 4 cycles
    bus.req = 4'b1010;
    for (int i = 0; i < 16; i++) begin
      step();
      check("rr_grant", 32'(bus.grant), ((i / 4) % 2 == 0) ? 32'h2 : 32'h8);
      check("rr_disp", 32'(disp_all), ((i / 4) % 2 == 0) ? 32'h00421 : 32'h18C63);
      check("rr_busy", 32'(bus.busy), 32'h1);
    end
    bus.req = 4'b0000;
    step();
    check("release_grant", 32'(bus.grant), 32'h0);
    check("release_disp", 32'(disp_all), 32'hFFFFF);
    bus.req = 4'b0100;
    step();
    check("own2_grant", 32'(bus.grant), 32'h4);
    check("own2_disp", 32'(disp_all), 32'h08888);
    step();
    check("own2_cnt", 32'(dut.cnt), 32'h1);
    bus.req = 4'b0001;
    step();
    check("drop_grant", 32'(bus.grant), 32'h1);
    check("drop_cnt", 32'(dut.cnt), 32'h0);
    check("drop_disp", 32'(disp_all), 32'h0A0A0);
    bus.req = 4'b0100;
    step();
    check("back2_grant", 32'(bus.grant), 32'h4);
    bus.req = 4'b0101;
`ifdef DISP_ARB_PRIORITY_EN
    step();
    check("preempt_grant", 32'(bus.grant), 32'h1);
    check("preempt_cnt", 32'(dut.cnt), 32'h0);
`else
    for (int i = 0; i < 3; i++) begin
      step();
      check("nopreempt_grant", 32'(bus.grant), 32'h4);
    end
    step();
    check("holdexp_grant", 32'(bus.grant), 32'h1);
`endif
    bus.req = 4'b0010;
    step();
    check("solo_grant", 32'(bus.grant), 32'h2);
    for (int i = 0; i < 12; i++) begin
      step();
      check("solo_hold", 32'(bus.grant), 32'h2);
    end
    bus.frame1 = 20'h12345;
    #1;
    check("frame_old", 32'(disp_all), 32'h00421);
    step();
    check("frame_new", 32'(disp_all), 32'h12345);
    rst = 1'b1;
    step();
    check("midrst_grant", 32'(bus.grant), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_disp", 32'(disp_all), 32'hFFFFF);
    rst = 1'b0;
    bus.req = 4'b1111;
    step();
    check("post_rst_grant", 32'(bus.grant), 32'h1);
    for (int i = 0; i < 3; i++) step();
    step();
`ifdef DISP_ARB_PRIORITY_EN
    check("all_hold0", 32'(bus.grant), 32'h1);
`else
    check("all_next", 32'(bus.grant), 32'h2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/disp_share_arbiter.md
DISP_SHARE_ARBITER -- requirements
Module: disp_share_arbiter

Interface
REQ-001 Parameter NBITS_HOLD, default 26, SHALL set the width of the hold counter.
REQ-002 Parameter HOLD, default 50_000_000 (0.5 s at 10 ns clk), SHALL set the grant hold time in clk cycles; legal range 1..2^NBITS_HOLD-1.
REQ-003 Parameter BLANK_CODE, default 5'h1F, SHALL be the 5-bit digit code driven when no requester is granted.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 req  input  4  SHALL carry one display request per requester; bit i is requester i.
REQ-007 frame0..frame3  input  20 each  SHALL carry requester i's digits as {digit3, digit2, digit1, digit0}, 5 bits each.
REQ-008 grant  output  4  SHALL be one-hot with the current owner, or all-zero when idle.
REQ-009 disp0..disp3  output  5 each  SHALL carry the digit codes for the downstream 4-digit sweep driver.
REQ-010 busy  output  1  SHALL be 1 whenever grant is non-zero.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHOW.
REQ-012 In IDLE, grant SHALL be 0 and all disp outputs SHALL be BLANK_CODE.
REQ-013 From IDLE, if any req bit is 1 at an edge, the FSM SHALL go to SHOW with grant set to the round-robin winner, and clear the hold counter.
REQ-014 The round-robin search SHALL start at (last_owner+1) mod 4 and wrap; last_owner SHALL reset to 3, so requester 0 wins first.
REQ-015 In SHOW, the disp outputs SHALL be registered copies of the granted requester's frame, with 1 cycle latency from a frame change to the disp change.
REQ-016 The first frame SHALL appear on disp in the same cycle grant first goes non-zero.
REQ-017 In SHOW, the hold counter SHALL increment by 1 every cycle.
REQ-018 If the owner's req is 0 at an edge in SHOW, the grant SHALL be released immediately: go to the next round-robin winner if any other req is 1, else to IDLE.
REQ-019 When the counter reaches HOLD-1 with owner's req still 1 and another req pending, the grant SHALL pass to the next round-robin winner and the counter SHALL clear.
REQ-020 When the counter reaches HOLD-1 with only the owner requesting, the owner SHALL keep the grant and the counter SHALL clear.
REQ-021 Every change of owner SHALL update last_owner.
REQ-022 An owner-to-owner handover SHALL take no IDLE cycle: grant changes directly from one one-hot value to the next.
REQ-023 With HOLD=1, the grant SHALL rotate every cycle among the asserted requesters.
REQ-024 The counter SHALL never exceed HOLD-1 and SHALL never wrap.

Reset
REQ-025 With rst=1 at an edge, the block SHALL take these values: state=IDLE, grant=0, busy=0, disp0..disp3=BLANK_CODE, counter=0, last_owner=3.
REQ-026 Reset SHALL override all other inputs, including in the middle of a grant; the next owner after reset is chosen as in REQ-014.

Configuration
REQ-027 When DISP_ARB_PRIORITY_EN is defined, requester 0 SHALL preempt: if req[0]=1 and grant[0]=0 in SHOW, the next edge gives grant=0001 and clears the counter, regardless of the hold counter.
REQ-028 Under DISP_ARB_PRIORITY_EN, requester 0 SHALL keep the grant while req[0]=1, with REQ-019 not applied to it, and requesters 1..3 SHALL share the display round-robin among themselves.
REQ-029 Without DISP_ARB_PRIORITY_EN, all four requesters SHALL be equal under pure round-robin, and req[0] SHALL not preempt.

Verification
REQ-030 The bench SHALL cover: rst=1 then release, req=0 -> grant=0, busy=0, all disp=5'h1F indefinitely.
REQ-031 The bench SHALL cover: HOLD=4, req=1010 constant, frame1=20'h00421, frame3=20'h18C63 -> grant 0010 for 4 cycles, then 1000 for 4 cycles, repeating; disp follows the matching frame.
REQ-032 The bench SHALL cover: owner 2 drops req[2] at counter=1 while req[0]=1 -> next edge grant=0001, counter=0.
REQ-033 The bench SHALL cover: single requester 1 held for 3*HOLD cycles -> grant stays 0010 with no gap; frame1 change -> disp changes 1 cycle later.
REQ-034 The bench SHALL cover: rst asserted mid-grant -> next edge IDLE/blank; with req=1111 after release, grant=0001 first.
REQ-035 The bench SHALL cover, with DISP_ARB_PRIORITY_EN: grant=0100, req[0] rises -> next edge grant=0001; without the macro -> grant stays 0100 until HOLD expires.
